full_adder_structural: RTL and testbench
========================================

// Module: full_adder_structural
//
// PURPOSE
// - 1-bit full adder built structurally from gate primitives: sum = a^b^c, carry = maj(a,b,c).
// - Leaf arithmetic cell for ripple-carry adders and lab datapaths.
// - Combinational outputs are always valid; a registered copy is provided for pipelined users.
//
// PARAMETERS
// - None. Width is fixed at 1 bit.
//
// PORTS
// - clk    input  1  system clock; registered outputs update on rising edge
// - rst    input  1  synchronous, active-high reset
// - a      input  1  addend bit
// - b      input  1  addend bit
// - c      input  1  carry-in bit
// - sum    output 1  combinational sum, a ^ b ^ c
// - carry  output 1  combinational carry-out, (a&b) | (c&(a^b))
// - sum_q  output 1  sum registered on clk
// - carry_q output 1 carry registered on clk
// - One clock domain; reset is synchronous and active-high (clk, rst).
//
// BEHAVIOUR
// Combinational path:
// - sum/carry depend only on a, b, c.
// - They are unaffected by clk and rst and have zero-cycle latency.
// - Required truth table for abc = 000..111:
//   - sum   = 0,1,1,0,1,0,0,1
//   - carry = 0,0,0,1,0,1,1,1
// - Gate netlist only, no behavioural '+'. Structure:
//   - HA1: s1 = a^b,  c1 = a&b
//   - HA2: sum = s1^c, c2 = s1&c
//   - carry = c1 | c2
// - X/Z on any input may propagate X to the outputs. No masking.
// Registered path:
// - On rising clk with rst=1: sum_q=0, carry_q=0.
// - On rising clk with rst=0: sum_q <= sum, carry_q <= carry. Latency is 1 cycle.
// - Reset asserted mid-operation clears both registers at the next edge. The combinational outputs keep tracking the inputs.
// - Power-up value before the first reset edge is undefined. The bench must apply rst first.
// - No enable and no handshake. The registers capture every cycle.
//
// STRUCTURE
// - Sub-module half_adder (a, b -> s, co) built from xor/and primitives. Instantiated twice.
// - One 'or' primitive combines the two carries.
// - A single always @(posedge clk) block holds sum_q/carry_q.
// - No shared package needed. No typedefs or constants.
//
// TESTING
// - Exhaustive combinational sweep:
//   - Apply abc = 000..111, 100 time units each, clk idle.
//   - sum/carry must match the truth table above at every step.
// - Reset:
//   - Hold rst=1 for 2 edges with a=b=c=1.
//   - Expect sum_q=0, carry_q=0, while sum=1, carry=1.
// - Pipeline latency:
//   - rst=0, abc=011 applied before edge N.
//   - Expect sum_q=0, carry_q=1 after edge N, not before.
// - Back-to-back vectors:
//   - Change abc every cycle through 101, 110, 111.
//   - (sum_q, carry_q) must lag by one cycle: (0,1), (0,1), (1,1).
// - Mid-stream reset:
//   - With abc=111 registered, pulse rst for one edge.
//   - Expect sum_q=carry_q=0 for that cycle, then (1,1) on the next edge.
// - Input glitch between edges:
//   - Toggle c twice between two clk edges.
//   - The registers reflect only the value sampled at the edge.

Source files
------------

// File: rtl/full_adder_structural_pkg.sv
// Shared types for the structural full adder: the registered result pair.
package full_adder_structural_pkg;

  typedef struct packed {
    logic sum;
    logic carry;
  } fa_result_t;

endpackage

// File: rtl/full_adder_structural_half_adder.sv
// Half adder built from gate primitives: s = a ^ b, co = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  xor u_xor (s, a, b);
  and u_and (co, a, b);

endmodule

// File: rtl/full_adder_structural.sv
// 1-bit full adder from two half adders and an OR gate, with a registered copy
// of sum/carry for pipelined users.
module full_adder_structural
  import full_adder_structural_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha1 (.a(a),  .b(b), .s(s1),  .co(c1));
  half_adder u_ha2 (.a(s1), .b(c), .s(sum), .co(c2));

  or u_or (carry, c1, c2);

  fa_result_t res_d;
  fa_result_t res_q;

  always_comb begin
    res_d       = '0;
    res_d.sum   = sum;
    res_d.carry = carry;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // rst is checked inside the clocked block, which makes it synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign sum_q   = res_q.sum;
  assign carry_q = res_q.carry;

endmodule

// File: tb/tb_full_adder_structural.sv
// Directed bench for full_adder_structural: truth-table sweep plus
// registered-path sequences (reset, latency, back-to-back, mid reset, glitch).
module tb_full_adder_structural;

  logic clk;
  logic clk_run;
  logic rst;
  logic a;
  logic b;
  logic c;
  logic sum;
  logic carry;
  logic sum_q;
  logic carry_q;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0] abc;
    logic       exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t comb_vecs[8];
  vec_t seq_vecs[3];

  full_adder_structural dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .sum    (sum),
    .carry  (carry),
    .sum_q  (sum_q),
    .carry_q(carry_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got (%b,%b) expected (%b,%b)", name, act[1], act[0], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_abc(input logic [2:0] v);
    a = v[2];
    b = v[1];
    c = v[0];
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk_run      = 1'b0;
    rst          = 1'b1;
    set_abc(3'b000);

    comb_vecs[0] = '{3'b000, 1'b0, 1'b0};
    comb_vecs[1] = '{3'b001, 1'b1, 1'b0};
    comb_vecs[2] = '{3'b010, 1'b1, 1'b0};
    comb_vecs[3] = '{3'b011, 1'b0, 1'b1};
    comb_vecs[4] = '{3'b100, 1'b1, 1'b0};
    comb_vecs[5] = '{3'b101, 1'b0, 1'b1};
    comb_vecs[6] = '{3'b110, 1'b0, 1'b1};
    comb_vecs[7] = '{3'b111, 1'b1, 1'b1};

    seq_vecs[0] = '{3'b101, 1'b0, 1'b1};
    seq_vecs[1] = '{3'b110, 1'b0, 1'b1};
    seq_vecs[2] = '{3'b111, 1'b1, 1'b1};

    // Combinational sweep with the clock held idle.
    for (int i = 0; i < 8; i++) begin
      set_abc(comb_vecs[i].abc);
      #100;
      check($sformatf("comb_abc_%b", comb_vecs[i].abc), {sum, carry},
            {comb_vecs[i].exp_sum, comb_vecs[i].exp_carry});
    end

    clk_run = 1'b1;

    // Reset held for two edges with all inputs high.
    rst = 1'b1;
    set_abc(3'b111);
    step();
    step();
    check("reset_regs", {sum_q, carry_q}, 2'b00);
    check("reset_comb", {sum, carry}, 2'b11);

    // Latency: 011 applied before edge N, visible only after it.
    rst = 1'b0;
    set_abc(3'b011);
    #1;
    check("latency_before_edge", {sum_q, carry_q}, 2'b00);
    check("latency_comb", {sum, carry}, 2'b01);
    step();
    check("latency_after_edge", {sum_q, carry_q}, 2'b01);

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < 3; i++) begin
      set_abc(seq_vecs[i].abc);
      step();
      check($sformatf("b2b_abc_%b", seq_vecs[i].abc), {sum_q, carry_q},
            {seq_vecs[i].exp_sum, seq_vecs[i].exp_carry});
    end

    // Mid-stream reset pulse with 111 already registered.
    check("midrst_pre", {sum_q, carry_q}, 2'b11);
    rst = 1'b1;
    step();
    check("midrst_regs_cleared", {sum_q, carry_q}, 2'b00);
    check("midrst_comb_tracks", {sum, carry}, 2'b11);
    rst = 1'b0;
    step();
    check("midrst_recover", {sum_q, carry_q}, 2'b11);

    // Glitch on c between edges; only the value at the edge is captured.
    set_abc(3'b110);
    #1 c = 1'b1;
    #1 c = 1'b0;
    #1 c = 1'b1;
    #1 c = 1'b0;
    check("glitch_hold", {sum_q, carry_q}, 2'b11);
    step();
    check("glitch_sampled", {sum_q, carry_q}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
